// File: rtl/connect4_win_checker.sv
// Connect-four win/draw checker: holds a 7x6 board, commits one column per move,
// then scans all 42 start cells at one per cycle with a fixed-latency report.
module connect4_win_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic       logic_reset,
  input  logic       logic_go,
  input  logic [2:0] mem_address,
  input  logic [5:0] write_to_onoff,
  input  logic [5:0] write_to_player,
  input  logic       cur_player,
  output logic       busy,
  output logic       done,
  output logic       logic_result,
  output logic       draw
);

  // state  | meaning
  // IDLE   | waiting for a move commit; results held
  // SCAN   | testing one start cell per cycle, (col,row) = (0,0) .. (6,5)
  // REPORT | done pulse; result and draw just registered
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t      r_state;
  logic [41:0] r_onoff;
  logic [41:0] r_owner;
  logic [2:0]  r_col;
  logic [2:0]  r_row;
  logic        r_player;
  logic        r_win;

  logic        w_hit;
  logic        w_win_final;
  logic        w_last;

  // Out-of-range cells read as "not ours", which covers the bounds rule and
  // keeps a line from wrapping across the column boundary.
  function automatic logic f_cell(input logic [41:0] on, input logic [41:0] pl,
                                  input int c, input int r, input logic p);
    logic [5:0] idx;
    idx = '0;
    if (c < 0 || c > 6 || r < 0 || r > 5) return 1'b0;
    idx = 6'(6 * c + r);
    return on[idx] & ~(pl[idx] ^ p);
  endfunction

  function automatic logic f_line(input logic [41:0] on, input logic [41:0] pl,
                                  input int c, input int r, input int dc,
                                  input int dr, input logic p);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) ok &= f_cell(on, pl, c + k * dc, r + k * dr, p);
    return ok;
  endfunction

  always_comb begin
    w_hit = 1'b0;
    w_hit = f_line(r_onoff, r_owner, int'(r_col), int'(r_row), 1, 0, r_player)
          | f_line(r_onoff, r_owner, int'(r_col), int'(r_row), 0, 1, r_player)
          | f_line(r_onoff, r_owner, int'(r_col), int'(r_row), 1, 1, r_player)
          | f_line(r_onoff, r_owner, int'(r_col), int'(r_row), 1, -1, r_player);
  end

  assign w_win_final = r_win | w_hit;
  assign w_last      = (r_col == 3'd6) && (r_row == 3'd5);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_onoff      <= '0;
      r_owner      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_player     <= 1'b0;
      r_win        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      logic_result <= 1'b0;
      draw         <= 1'b0;
    end else if (logic_reset) begin
      r_state      <= IDLE;
      r_onoff      <= '0;
      r_owner      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_win        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      logic_result <= 1'b0;
      draw         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (logic_go) begin
            for (int c = 0; c < 7; c++) begin
              if (mem_address == 3'(c)) begin
                r_onoff[6*c +: 6] <= write_to_onoff;
                r_owner[6*c +: 6] <= write_to_player;
              end
            end
            r_player     <= cur_player;
            r_win        <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            logic_result <= 1'b0;
            draw         <= 1'b0;
            busy         <= 1'b1;
            r_state      <= SCAN;
          end
        end
        SCAN: begin
          r_win <= w_win_final;
          if (w_last) begin
            busy         <= 1'b0;
            done         <= 1'b1;
            logic_result <= w_win_final;
            draw         <= (&r_onoff) & ~w_win_final;
            r_state      <= REPORT;
          end else if (r_row == 3'd5) begin
            r_row <= '0;
            r_col <= r_col + 3'd1;
          end else begin
            r_row <= r_row + 3'd1;
          end
        end
        REPORT: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_win_checker.sv
// Directed bench for connect4_win_checker: timing, win directions, draw,
// clear/reset priority and ignored mid-scan commits.
module tb_connect4_win_checker;

  logic       clk;
  logic       reset;
  logic       logic_reset;
  logic       logic_go;
  logic [2:0] mem_address;
  logic [5:0] write_to_onoff;
  logic [5:0] write_to_player;
  logic       cur_player;
  logic       busy;
  logic       done;
  logic       logic_result;
  logic       draw;

  int n_checks = 0;
  int n_err    = 0;
  logic res, drw;
  int bad;

  connect4_win_checker dut (
    .clk            (clk),
    .reset          (reset),
    .logic_reset    (logic_reset),
    .logic_go       (logic_go),
    .mem_address    (mem_address),
    .write_to_onoff (write_to_onoff),
    .write_to_player(write_to_player),
    .cur_player     (cur_player),
    .busy           (busy),
    .done           (done),
    .logic_result   (logic_result),
    .draw           (draw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Commit a column and follow the fixed 43-cycle latency to the report.
  task automatic move(input string tag, input logic [2:0] a, input logic [5:0] on,
                      input logic [5:0] pl, input logic cp,
                      output logic o_res, output logic o_drw);
    int nbad;
    nbad = 0;
    logic_go = 1'b1; mem_address = a; write_to_onoff = on;
    write_to_player = pl; cur_player = cp;
    tick();
    logic_go = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) nbad++;
      tick();
    end
    chk({tag, "_busy_window"}, nbad, 0);
    chk({tag, "_done_n43"}, int'(done), 1);
    o_res = logic_result;
    o_drw = draw;
    tick();
    chk({tag, "_done_pulse"}, int'(done), 0);
  endtask

  task automatic clear_game();
    logic_reset = 1'b1;
    tick();
    logic_reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; logic_reset = 1'b0; logic_go = 1'b0; mem_address = 3'd0;
    write_to_onoff = '0; write_to_player = '0; cur_player = 1'b0;
    tick(); tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(logic_result), 0);
    chk("rst_draw", int'(draw), 0);
    reset = 1'b1;
    tick();

    move("empty", 3'd7, 6'b111111, 6'b000000, 1'b0, res, drw);
    chk("empty_res", int'(res), 0);
    chk("empty_draw", int'(drw), 0);

    move("vert", 3'd3, 6'b001111, 6'b000000, 1'b0, res, drw);
    chk("vert_res", int'(res), 1);
    chk("vert_draw", int'(drw), 0);
    repeat (5) tick();
    chk("vert_hold", int'(logic_result), 1);
    move("vert_p1", 3'd7, 6'b0, 6'b0, 1'b1, res, drw);
    chk("vert_p1_res", int'(res), 0);

    clear_game();
    chk("clr_result", int'(logic_result), 0);
    chk("clr_busy", int'(busy), 0);

    move("h0", 3'd0, 6'b000001, 6'b000001, 1'b1, res, drw);
    move("h1", 3'd1, 6'b000001, 6'b000001, 1'b1, res, drw);
    move("h2", 3'd2, 6'b000001, 6'b000001, 1'b1, res, drw);
    move("h4", 3'd4, 6'b000001, 6'b000001, 1'b1, res, drw);
    chk("h_nearmiss", int'(res), 0);
    move("h3", 3'd3, 6'b000001, 6'b000001, 1'b1, res, drw);
    chk("h_win", int'(res), 1);
    move("h_p0", 3'd7, 6'b0, 6'b0, 1'b0, res, drw);
    chk("h_other_player", int'(res), 0);

    clear_game();
    move("d0", 3'd0, 6'b000001, 6'b000000, 1'b0, res, drw);
    move("d1", 3'd1, 6'b000011, 6'b000001, 1'b0, res, drw);
    move("d2", 3'd2, 6'b000111, 6'b000011, 1'b0, res, drw);
    chk("diag_up_partial", int'(res), 0);
    move("d3", 3'd3, 6'b001111, 6'b000111, 1'b0, res, drw);
    chk("diag_up_win", int'(res), 1);

    clear_game();
    move("a6", 3'd6, 6'b000001, 6'b000001, 1'b1, res, drw);
    move("a5", 3'd5, 6'b000011, 6'b000010, 1'b1, res, drw);
    move("a4", 3'd4, 6'b000111, 6'b000100, 1'b1, res, drw);
    chk("diag_dn_partial", int'(res), 0);
    move("a3", 3'd3, 6'b001111, 6'b001000, 1'b1, res, drw);
    chk("diag_dn_win", int'(res), 1);

    clear_game();
    move("w5", 3'd5, 6'b000001, 6'b000000, 1'b0, res, drw);
    move("w6", 3'd6, 6'b000001, 6'b000000, 1'b0, res, drw);
    move("w0", 3'd0, 6'b000001, 6'b000000, 1'b0, res, drw);
    move("w1", 3'd1, 6'b000001, 6'b000000, 1'b0, res, drw);
    chk("wrap_horiz", int'(res), 0);

    clear_game();
    move("v0", 3'd0, 6'b111111, 6'b001111, 1'b0, res, drw);
    move("v1", 3'd1, 6'b000011, 6'b000000, 1'b0, res, drw);
    chk("wrap_vert", int'(res), 0);

    // Owner = row[0] ^ col[1]: no four in a row for either player.
    clear_game();
    move("f0", 3'd0, 6'b111111, 6'b101010, 1'b0, res, drw);
    move("f1", 3'd1, 6'b111111, 6'b101010, 1'b0, res, drw);
    move("f2", 3'd2, 6'b111111, 6'b010101, 1'b0, res, drw);
    move("f3", 3'd3, 6'b111111, 6'b010101, 1'b0, res, drw);
    move("f4", 3'd4, 6'b111111, 6'b101010, 1'b0, res, drw);
    move("f5", 3'd5, 6'b111111, 6'b101010, 1'b0, res, drw);
    chk("full_not_yet_draw", int'(drw), 0);
    move("f6", 3'd6, 6'b111111, 6'b010101, 1'b0, res, drw);
    chk("full_res", int'(res), 0);
    chk("full_draw", int'(drw), 1);
    move("full_p1", 3'd7, 6'b0, 6'b0, 1'b1, res, drw);
    chk("full_p1_res", int'(res), 0);
    chk("full_p1_draw", int'(drw), 1);
    move("full_win", 3'd0, 6'b111111, 6'b000000, 1'b0, res, drw);
    chk("full_win_res", int'(res), 1);
    chk("full_win_draw", int'(drw), 0);

    // Clear at N+20 aborts the scan.
    logic_go = 1'b1; mem_address = 3'd7; cur_player = 1'b0;
    tick();
    logic_go = 1'b0;
    repeat (19) tick();
    logic_reset = 1'b1;
    tick();
    logic_reset = 1'b0;
    chk("midclr_busy", int'(busy), 0);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    chk("midclr_no_done", bad, 0);
    move("midclr_board", 3'd7, 6'b0, 6'b0, 1'b0, res, drw);
    chk("midclr_res", int'(res), 0);
    chk("midclr_draw", int'(drw), 0);

    // Commit at N+5 must be ignored; done still at N+43.
    logic_go = 1'b1; mem_address = 3'd7; cur_player = 1'b0;
    tick();
    logic_go = 1'b0;
    repeat (4) tick();
    logic_go = 1'b1; mem_address = 3'd3; write_to_onoff = 6'b001111;
    write_to_player = 6'b000000;
    tick();
    logic_go = 1'b0;
    repeat (37) tick();
    chk("late_go_done_n43", int'(done), 1);
    chk("late_go_res", int'(logic_result), 0);
    tick();
    chk("late_go_idle", int'(busy), 0);

    // cur_player changes mid-scan have no effect.
    move("cp_setup", 3'd3, 6'b001111, 6'b000000, 1'b0, res, drw);
    logic_go = 1'b1; mem_address = 3'd7; cur_player = 1'b0;
    tick();
    logic_go = 1'b0;
    cur_player = 1'b1;
    repeat (42) tick();
    chk("cp_latch_done", int'(done), 1);
    chk("cp_latch_res", int'(logic_result), 1);
    tick();

    // Clear wins over a simultaneous commit.
    logic_reset = 1'b1; logic_go = 1'b1; mem_address = 3'd2;
    write_to_onoff = 6'b001111; write_to_player = 6'b000000;
    tick();
    logic_reset = 1'b0; logic_go = 1'b0;
    chk("collide_busy", int'(busy), 0);
    move("collide_board", 3'd7, 6'b0, 6'b0, 1'b0, res, drw);
    chk("collide_res", int'(res), 0);

    // Synchronous reset wins over clear and commit.
    move("rp_setup", 3'd4, 6'b001111, 6'b000000, 1'b0, res, drw);
    chk("rp_setup_res", int'(res), 1);
    reset = 1'b0; logic_reset = 1'b1; logic_go = 1'b1; mem_address = 3'd5;
    tick();
    reset = 1'b1; logic_reset = 1'b0; logic_go = 1'b0;
    chk("rp_result", int'(logic_result), 0);
    chk("rp_busy", int'(busy), 0);
    move("rp_board", 3'd7, 6'b0, 6'b0, 1'b0, res, drw);
    chk("rp_board_res", int'(res), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
